// File: rtl/glb_psum_write_arbiter_if.sv
// glb_psum_write_arbiter_if: psum router request/burst bus plus GLB psum write port.
// err_timeout exists only when PSUM_ARB_TIMEOUT_EN is defined.
interface glb_psum_write_arbiter_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 3
);
  logic [NUM_REQ-1:0]                   req;
  logic [NUM_REQ-1:0]                   psum_ctrl;
  logic [NUM_REQ-1:0]                   wr_en_in;
  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] wr_addr_in;
  logic [NUM_REQ*DATA_BITWIDTH-1:0]     wr_data_in;
  logic                                 write_en_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0]         w_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]             w_data_glb_psum;
  logic [NUM_REQ-1:0]                   ack;
  logic                                 busy;
  logic                                 err_stray;
`ifdef PSUM_ARB_TIMEOUT_EN
  logic                                 err_timeout;

  modport master (
    output req, wr_en_in, wr_addr_in, wr_data_in,
    input  psum_ctrl, write_en_glb_psum, w_addr_glb_psum,
    input  w_data_glb_psum, ack, busy, err_stray, err_timeout
  );

  modport slave (
    input  req, wr_en_in, wr_addr_in, wr_data_in,
    output psum_ctrl, write_en_glb_psum, w_addr_glb_psum,
    output w_data_glb_psum, ack, busy, err_stray, err_timeout
  );
`else
  modport master (
    output req, wr_en_in, wr_addr_in, wr_data_in,
    input  psum_ctrl, write_en_glb_psum, w_addr_glb_psum,
    input  w_data_glb_psum, ack, busy, err_stray
  );

  modport slave (
    input  req, wr_en_in, wr_addr_in, wr_data_in,
    output psum_ctrl, write_en_glb_psum, w_addr_glb_psum,
    output w_data_glb_psum, ack, busy, err_stray
  );
`endif
endinterface

// File: rtl/glb_psum_write_arbiter.sv
// glb_psum_write_arbiter: round-robin owner of the single GLB psum write port.
// Define PSUM_ARB_TIMEOUT_EN to add the WAIT_BURST watchdog and err_timeout.
module glb_psum_write_arbiter #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 3,
  parameter int BURST_LEN         = 5,
  parameter int TIMEOUT           = 64
) (
  input logic                    clk,
  input logic                    reset,
  glb_psum_write_arbiter_if.slave bus
);

  localparam int DW = DATA_BITWIDTH;
  localparam int AW = ADDR_BITWIDTH_GLB;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  if (BURST_LEN < 1 || TIMEOUT < 1) begin : g_cfg_check
    $error("BURST_LEN and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BURST,
    RELEASE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      pick;
  logic               found;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] allowed;
  logic               sel_en;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic [CW-1:0]      beat_cnt;
  logic               beat;
  logic               last_beat;
  logic               to_hit;
  logic               stray;

  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      data_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               stray_q;

  // Round-robin pick: first req bit after ptr, wrapping
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(ptr) + k) % NUM_REQ && bus.req[i]) begin
          pick  = GW'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Select the granted router's write lane
  always_comb begin
    grant_oh = '0;
    sel_en   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == GW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_en      = bus.wr_en_in[i];
        sel_addr    = bus.wr_addr_in[i*AW +: AW];
        sel_data    = bus.wr_data_in[i*DW +: DW];
      end
    end
  end

  assign beat      = (state == WAIT_BURST) && sel_en;
  assign last_beat = beat && (beat_cnt == CW'(BURST_LEN - 1));
  assign allowed   = (state == WAIT_BURST) ? grant_oh : '0;
  assign stray     = |(bus.wr_en_in & ~allowed);

`ifdef PSUM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wdog;
  logic          err_to_q;

  assign to_hit = (state == WAIT_BURST) && !sel_en &&
                  (wdog == TW'(TIMEOUT - 1));

  // Watchdog: idle WAIT_BURST cycles since entry or last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog     <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (state != WAIT_BURST || sel_en) wdog <= '0;
      else                               wdog <= wdog + 1'b1;
      if (to_hit) err_to_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_to_q;
`else
  assign to_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (found) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_BURST;
      WAIT_BURST: if (last_beat || to_hit) state_nxt = RELEASE;
      RELEASE:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs: control pulse in ISSUE, busy outside IDLE
  always_comb begin
    bus.psum_ctrl = (state == ISSUE) ? grant_oh : '0;
    bus.busy      = (state != IDLE);
  end

  // Grant, RR pointer and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      ptr      <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && found) grant <= pick;
      if (state == ISSUE) beat_cnt <= '0;
      else if (beat)      beat_cnt <= beat_cnt + 1'b1;
      if (last_beat || to_hit) ptr <= grant;
    end
  end

  // Registered GLB port, ack pulse and sticky stray flag
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      we_q  <= beat;
      ack_q <= last_beat ? grant_oh : '0;
      if (beat) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      if (stray) stray_q <= 1'b1;
    end
  end

  assign bus.write_en_glb_psum = we_q;
  assign bus.w_addr_glb_psum   = addr_q;
  assign bus.w_data_glb_psum   = data_q;
  assign bus.ack               = ack_q;
  assign bus.err_stray         = stray_q;

endmodule
